// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encoding, frame layout and frame builder for the PS/2 device transmitter
package ps2_pkg;

    typedef enum logic [2:0] {IDLE, WAIT_BUS, BIT_HIGH, BIT_LOW, END} ps2_state_e;

    localparam int PS2_FRAME_BITS = 11;
    localparam int START_POS      = 0;
    localparam int PARITY_POS     = 9;
    localparam int STOP_POS       = 10;

    // Frame is shifted out LSB first: start(0), data[7:0], odd parity, stop(1).
    function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] d);
        logic [PS2_FRAME_BITS-1:0] f;
        f             = '0;
        f[START_POS]  = 1'b0;
        f[8:1]        = d;
        f[PARITY_POS] = ~^d;
        f[STOP_POS]   = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous line input
//   clk, rst_n : clock and async active-low reset
//   d_i        : asynchronous input
//   q_o        : synchronized output (2-cycle latency), resets to RST_VAL
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q, sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ps2_device_tx.sv
// ps2_device_tx: device-side PS/2 transmitter driving open-drain clock/data, one byte per frame
//   clk, rst_n               : clock, async active-low reset
//   tx_valid, tx_data        : byte offer; accepted when tx_valid & tx_ready
//   tx_ready                 : high when no byte is held
//   ps2_clk_in, ps2_data_in  : sensed line levels (asynchronous)
//   ps2_clk_oe, ps2_data_oe  : 1 pulls the line low, 0 releases it
//   busy                     : byte held (waiting for bus or transmitting)
//   tx_done, tx_abort        : one-cycle pulses, frame completed / aborted by host inhibit
//   host_rts                 : idle with clock high and data low (host request-to-send)
module ps2_device_tx
    import ps2_pkg::*;
#(
    parameter int unsigned HALF_PER  = 2500,
    parameter int unsigned IDLE_HOLD = 3750
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_abort,
    output logic       host_rts
);

    localparam int unsigned CMAX = (HALF_PER > IDLE_HOLD) ? HALF_PER : IDLE_HOLD;
    localparam int CW = $clog2(CMAX + 1);

    ps2_state_e                state_q;
    logic [CW-1:0]             cnt_q;
    logic [3:0]                idx_q;
    logic [PS2_FRAME_BITS-1:0] frame_q;
    logic                      clk_oe_q, data_oe_q, busy_q, done_q, abort_q;
    logic                      clk_s, data_s, half_last;

    sync_2ff u_sync_clk  (.clk(clk), .rst_n(rst_n), .d_i(ps2_clk_in),  .q_o(clk_s));
    sync_2ff u_sync_data (.clk(clk), .rst_n(rst_n), .d_i(ps2_data_in), .q_o(data_s));

    assign half_last = cnt_q == CW'(HALF_PER - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            frame_q   <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            // busy drops one cycle after the done pulse so tx_ready follows tx_done
            if (done_q)
                busy_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tx_valid && !busy_q) begin
                        frame_q <= ps2_frame(tx_data);
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= WAIT_BUS;
                    end
                end
                WAIT_BUS: begin
                    if (clk_s && data_s) begin
                        if (cnt_q == CW'(IDLE_HOLD - 1)) begin
                            cnt_q     <= '0;
                            idx_q     <= '0;
                            clk_oe_q  <= 1'b0;
                            data_oe_q <= ~frame_q[START_POS];
                            state_q   <= BIT_HIGH;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= '0;
                    end
                end
                BIT_HIGH: begin
                    if (half_last) begin
                        cnt_q <= '0;
                        // clock released by us yet sensed low: host is inhibiting (stop bit exempt)
                        if (idx_q <= 4'd9 && !clk_s) begin
                            clk_oe_q  <= 1'b0;
                            data_oe_q <= 1'b0;
                            abort_q   <= 1'b1;
                            state_q   <= WAIT_BUS;
                        end else begin
                            clk_oe_q <= 1'b1;
                            state_q  <= BIT_LOW;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                BIT_LOW: begin
                    if (half_last) begin
                        cnt_q    <= '0;
                        clk_oe_q <= 1'b0;
                        if (idx_q == 4'(STOP_POS)) begin
                            data_oe_q <= 1'b0;
                            state_q   <= END;
                        end else begin
                            idx_q     <= idx_q + 4'd1;
                            data_oe_q <= ~frame_q[idx_q + 4'd1];
                            state_q   <= BIT_HIGH;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                END: begin
                    if (half_last) begin
                        cnt_q   <= '0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_ready    = ~busy_q;
    assign busy        = busy_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx_done     = done_q;
    assign tx_abort    = abort_q;
    assign host_rts    = (state_q == IDLE) & clk_s & ~data_s;

endmodule

// File: tb/tb_ps2_device_tx.sv
// tb_ps2_device_tx: randomized frame checks of ps2_device_tx against a PS/2 host line model
module tb_ps2_device_tx;

    localparam int H  = 4;
    localparam int IH = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic       busy, tx_done, tx_abort, host_rts;
    logic       host_clk_pull = 1'b0, host_data_pull = 1'b0;

    int n_vec = 0, n_err = 0;
    int cyc = 0, start_cyc = 0, n_abort = 0;
    bit got[$];
    logic prev_coe = 1'b0, prev_doe = 1'b0;

    ps2_device_tx #(.HALF_PER(H), .IDLE_HOLD(IH)) dut (
        .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in), .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe), .busy(busy), .tx_done(tx_done), .tx_abort(tx_abort),
        .host_rts(host_rts)
    );

    always #5 clk = ~clk;

    // open-drain wired-AND with pull-ups: low if either side pulls
    assign ps2_clk_in  = ~(ps2_clk_oe | host_clk_pull);
    assign ps2_data_in = ~(ps2_data_oe | host_data_pull);

    always @(posedge clk) cyc <= cyc + 1;

    // host-side view: data captured on every falling clock edge
    always @(negedge clk) begin
        if (!rst_n) begin
            got.delete();
        end else begin
            if (tx_valid && tx_ready) got.delete();
            if (tx_abort) begin
                got.delete();
                n_abort++;
            end
            if (!prev_doe && ps2_data_oe && got.size() == 0) start_cyc = cyc;
            if (!prev_coe && ps2_clk_oe) got.push_back(ps2_data_in);
        end
        prev_coe = ps2_clk_oe;
        prev_doe = ps2_data_oe;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    // reference frame: start 0, data LSB first, parity makes the 1-count odd, stop 1
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        logic [10:0] f;
        f[0]    = 1'b0;
        f[8:1]  = d;
        f[9]    = ($countones(d) % 2 == 0);
        f[10]   = 1'b1;
        return f;
    endfunction

    task automatic start(input logic [7:0] d, input bit junk);
        int i;
        i = 0;
        @(posedge clk); #1;
        while (!tx_ready && i < 500) begin
            @(posedge clk); #1;
            i++;
        end
        check("ready_wait", tx_ready, 1);
        tx_valid = 1'b1;
        tx_data  = d;
        @(posedge clk); #1;
        if (junk) tx_data = 8'($urandom);
        else tx_valid = 1'b0;
        check("busy_set", busy, 1);
    endtask

    task automatic finish(input logic [7:0] d);
        bit ok;
        logic [10:0] v;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (tx_done) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_seen", ok, 1);
        if (ok) begin
            v = '0;
            for (int k = 0; k < got.size() && k < 11; k++) v[k] = got[k];
            check("edges", got.size(), 11);
            check("frame", v, model_frame(d));
            check("duration", cyc - start_cyc, 23 * H);
            check("ready_at_done", tx_ready, 0);
            tx_valid = 1'b0;
            @(negedge clk);
            check("ready_after", tx_ready, 1);
            check("busy_after", busy, 0);
        end
        tx_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input bit junk);
        start(d, junk);
        finish(d);
    endtask

    initial begin
        bit ok;
        int ab, act, rel;
        logic [7:0] d;
        repeat (3) @(negedge clk);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_coe", ps2_clk_oe, 0);
        check("rst_doe", ps2_data_oe, 0);
        check("rst_done", tx_done, 0);
        check("rst_abort", tx_abort, 0);
        check("rst_rts", host_rts, 0);
        rst_n = 1'b1;

        send(8'h1C, 1'b0);
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        send(8'h01, 1'b0);
        for (int n = 0; n < 10; n++) begin
            repeat ($urandom_range(0, 4)) @(posedge clk);
            send(8'($urandom), 1'($urandom_range(0, 1)));
        end

        // host inhibit during the bit-4 high phase
        start(8'h1C, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (got.size() == 4 && !ps2_clk_oe) begin
                ok = 1'b1;
                break;
            end
        end
        check("bit4_reached", ok, 1);
        host_clk_pull = 1'b1;
        ab = n_abort;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_abort) begin
                ok = 1'b1;
                break;
            end
        end
        check("abort_seen", ok, 1);
        check("abort_coe", ps2_clk_oe, 0);
        check("abort_doe", ps2_data_oe, 0);
        check("abort_busy", busy, 1);
        act = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_done || ps2_clk_oe || ps2_data_oe) act++;
        end
        check("inhibit_quiet", act, 0);
        check("inhibit_busy", busy, 1);
        host_clk_pull = 1'b0;
        finish(8'h1C);
        check("abort_count", n_abort - ab, 1);

        // host inhibit during the stop bit is ignored
        d = 8'($urandom);
        start(d, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (got.size() == 10 && !ps2_clk_oe) begin
                ok = 1'b1;
                break;
            end
        end
        check("stop_reached", ok, 1);
        host_clk_pull = 1'b1;
        ab = n_abort;
        finish(d);
        check("stop_no_abort", n_abort - ab, 0);
        host_clk_pull = 1'b0;

        // host request-to-send: data held low while idle
        host_data_pull = 1'b1;
        repeat (4) @(negedge clk);
        check("rts", host_rts, 1);
        start(8'h5A, 1'b0);
        act = 0;
        repeat (30) begin
            @(negedge clk);
            if (ps2_clk_oe || ps2_data_oe) act++;
        end
        check("rts_wait_quiet", act, 0);
        check("rts_wait_busy", busy, 1);
        check("rts_not_idle", host_rts, 0);
        @(negedge clk);
        rel = cyc;
        host_data_pull = 1'b0;
        finish(8'h5A);
        check("rts_hold", start_cyc - rel, IH + 2);

        // asynchronous reset in the middle of a low clock phase
        start(8'h33, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ps2_clk_oe) begin
                ok = 1'b1;
                break;
            end
        end
        check("low_reached", ok, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_coe", ps2_clk_oe, 0);
        check("arst_doe", ps2_data_oe, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_ready", tx_ready, 1);
        check("arst_busy", busy, 0);
        act = 0;
        repeat (150) begin
            @(negedge clk);
            if (ps2_clk_oe || ps2_data_oe || busy || tx_done) act++;
        end
        check("arst_discard", act, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
